// File: rtl/cmd_pkg.sv
// Shared definitions for the command dispatcher: packet layout, opcodes,
// status bit positions and the dispatcher FSM encoding.
package cmd_pkg;

  localparam int B_OPC   = 0;
  localparam int B_LEN   = 1;
  localparam int B_COUNT = 3;
  localparam int B_START = 4;
  localparam int B_PAY_B = 5;

  localparam logic [7:0] OPC_EDGE  = 8'h01;
  localparam logic [7:0] OPC_VTX_A = 8'h02;
  localparam logic [7:0] OPC_VTX_B = 8'h03;
  localparam logic [7:0] OPC_VTX_C = 8'h04;

  localparam int SB_OPCODE  = 0;
  localparam int SB_NOACK   = 1;
  localparam int SB_TIMEOUT = 2;
  localparam int SB_LEN     = 3;
  localparam int SB_RANGE   = 4;
  localparam int SB_PROTO   = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  function automatic logic [7:0] status_bit(input int idx);
    return 8'h01 << idx;
  endfunction

  // Loader flags {proto, range, len} land on status bits [5:3].
  function automatic logic [7:0] loader_status(input logic [2:0] err);
    return {2'b00, err, 3'b000};
  endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Clearable saturating cycle counter with the ack and done expiry compares.
module cmd_watchdog #(
  parameter int ACK_WAIT = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic CLK,
  input  logic rst,
  input  logic clr,
  output logic ack_expired,
  output logic done_expired
);

  localparam int LIMIT = (ACK_WAIT > TIMEOUT) ? ACK_WAIT : TIMEOUT;
  localparam int TW    = $clog2(LIMIT + 1);

  // Expiry fires in the last allowed cycle so the FSM leaves exactly on the limit.
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_WAIT - 1);
  localparam logic [TW-1:0] DONE_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_MAX   = TW'(LIMIT);

  logic [TW-1:0] count_reg;

  always_ff @(posedge CLK) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (count_reg != CNT_MAX) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign ack_expired  = (count_reg >= ACK_LAST);
  assign done_expired = (count_reg >= DONE_LAST);

endmodule

// File: rtl/cmd_dispatch.sv
// Command sequencer: decodes one packet at a time, starts the selected loader,
// supervises its BUSY handshake and reports a status word per command.
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int         NUM_TGT     = 4,
  parameter int         PACKET_SIZE = 256,
  parameter logic [7:0] OPC_BASE    = OPC_EDGE,
  parameter int         ACK_WAIT    = 4,
  parameter int         TIMEOUT     = 1024
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         pkt_valid,
  output logic                         pkt_ready,
  input  logic [7:0]                   pkt_len,
  input  logic [8*PACKET_SIZE-1:0]     pkt_data,
  output logic [NUM_TGT-1:0]           tgt_req_pulse,
  output logic [7:0]                   tgt_len,
  output logic [8*PACKET_SIZE-1:0]     tgt_packet,
  input  logic [NUM_TGT-1:0]           tgt_busy,
  input  logic [3*NUM_TGT-1:0]         tgt_err,
  output logic [NUM_TGT-1:0]           tgt_rst,
  output logic                         done_pulse,
  output logic [7:0]                   status,
  output logic [$clog2(NUM_TGT)-1:0]   status_tgt,
  output logic [15:0]                  cmd_count
);

  localparam int IDX_W = $clog2(NUM_TGT);

  state_t                   state_reg, state_next;
  logic [IDX_W-1:0]         tgt_idx_reg, tgt_idx_next;
  logic [7:0]               stat_pend_reg, stat_pend_next;
  logic [7:0]               status_reg;
  logic [IDX_W-1:0]         status_tgt_reg;
  logic                     done_pulse_reg;
  logic [15:0]              cmd_count_reg;
  logic [7:0]               tgt_len_reg;
  logic [8*PACKET_SIZE-1:0] tgt_packet_reg;

  logic                     accept;
  logic                     issue_fire;
  logic                     hang_fire;
  logic                     wd_clr;
  logic                     ack_expired;
  logic                     done_expired;

  logic [7:0]               opc;
  logic [NUM_TGT-1:0]       opc_hit;
  logic [IDX_W-1:0]         opc_idx;
  logic                     opc_valid;
  logic [2:0]               err_arr [NUM_TGT];
  logic                     busy_sel;
  logic [2:0]               err_sel;

  assign opc = pkt_data[8*B_OPC +: 8];

  // Per-target decode, flag slicing and one-hot strobes.
  generate
    for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_tgt
      assign opc_hit[gi]       = (opc >= OPC_BASE) && ((opc - OPC_BASE) == 8'(gi));
      assign err_arr[gi]       = tgt_err[3*gi +: 3];
      assign tgt_req_pulse[gi] = issue_fire && (tgt_idx_reg == IDX_W'(gi));
      assign tgt_rst[gi]       = hang_fire && (tgt_idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    opc_idx = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (opc_hit[i]) begin
        opc_idx = IDX_W'(i);
      end
    end
  end

  assign opc_valid = |opc_hit;
  assign busy_sel  = tgt_busy[tgt_idx_reg];
  assign err_sel   = err_arr[tgt_idx_reg];

  cmd_watchdog #(
    .ACK_WAIT (ACK_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) u_watchdog (
    .CLK          (CLK),
    .rst          (rst),
    .clr          (wd_clr),
    .ack_expired  (ack_expired),
    .done_expired (done_expired)
  );

  // Strobes are decided in the cycle the condition holds; rst masks them so an
  // abandoned command never kicks or resets a loader.
  always_comb begin
    state_next     = state_reg;
    tgt_idx_next   = tgt_idx_reg;
    stat_pend_next = stat_pend_reg;
    accept         = 1'b0;
    issue_fire     = 1'b0;
    hang_fire      = 1'b0;
    wd_clr         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (pkt_valid) begin
          accept = 1'b1;
          if (opc_valid) begin
            tgt_idx_next = opc_idx;
            state_next   = S_ISSUE;
          end else begin
            tgt_idx_next   = '0;
            stat_pend_next = status_bit(SB_OPCODE);
            state_next     = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        if (!busy_sel) begin
          issue_fire = !rst;
          wd_clr     = 1'b1;
          state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (busy_sel) begin
          wd_clr     = 1'b1;
          state_next = S_WAIT_DONE;
        end else if (ack_expired) begin
          stat_pend_next = status_bit(SB_NOACK);
          state_next     = S_RESP;
        end
      end
      S_WAIT_DONE: begin
        if (!busy_sel) begin
          stat_pend_next = loader_status(err_sel);
          state_next     = S_RESP;
        end else if (done_expired) begin
          hang_fire      = !rst;
          stat_pend_next = status_bit(SB_TIMEOUT);
          state_next     = S_RESP;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      tgt_idx_reg    <= '0;
      stat_pend_reg  <= '0;
      status_reg     <= '0;
      status_tgt_reg <= '0;
      done_pulse_reg <= 1'b0;
      cmd_count_reg  <= '0;
      tgt_len_reg    <= '0;
      tgt_packet_reg <= '0;
    end else begin
      state_reg      <= state_next;
      tgt_idx_reg    <= tgt_idx_next;
      stat_pend_reg  <= stat_pend_next;
      done_pulse_reg <= (state_reg == S_RESP);
      if (state_reg == S_RESP) begin
        status_reg     <= stat_pend_reg;
        status_tgt_reg <= tgt_idx_reg;
        cmd_count_reg  <= cmd_count_reg + 16'd1;
      end
      if (accept) begin
        tgt_packet_reg <= pkt_data;
        tgt_len_reg    <= pkt_len;
      end
    end
  end

  assign pkt_ready  = (state_reg == S_IDLE);
  assign tgt_len    = tgt_len_reg;
  assign tgt_packet = tgt_packet_reg;
  assign done_pulse = done_pulse_reg;
  assign status     = status_reg;
  assign status_tgt = status_tgt_reg;
  assign cmd_count  = cmd_count_reg;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Scoreboard bench for cmd_dispatch with behavioural loader models per target.
module tb_cmd_dispatch;

  localparam int NUM_TGT     = 4;
  localparam int PACKET_SIZE = 256;
  localparam int ACK_WAIT    = 4;
  localparam int TIMEOUT     = 16;
  localparam int PW          = 8 * PACKET_SIZE;

  localparam int M_NORMAL = 0;
  localparam int M_NOACK  = 1;
  localparam int M_HANG   = 2;

  logic                 CLK;
  logic                 rst;
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [7:0]           pkt_len;
  logic [PW-1:0]        pkt_data;
  logic [NUM_TGT-1:0]   tgt_req_pulse;
  logic [7:0]           tgt_len;
  logic [PW-1:0]        tgt_packet;
  logic [NUM_TGT-1:0]   tgt_busy;
  logic [3*NUM_TGT-1:0] tgt_err;
  logic [NUM_TGT-1:0]   tgt_rst;
  logic                 done_pulse;
  logic [7:0]           status;
  logic [1:0]           status_tgt;
  logic [15:0]          cmd_count;

  cmd_dispatch #(
    .NUM_TGT     (NUM_TGT),
    .PACKET_SIZE (PACKET_SIZE),
    .OPC_BASE    (8'h01),
    .ACK_WAIT    (ACK_WAIT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .CLK           (CLK),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .pkt_len       (pkt_len),
    .pkt_data      (pkt_data),
    .tgt_req_pulse (tgt_req_pulse),
    .tgt_len       (tgt_len),
    .tgt_packet    (tgt_packet),
    .tgt_busy      (tgt_busy),
    .tgt_err       (tgt_err),
    .tgt_rst       (tgt_rst),
    .done_pulse    (done_pulse),
    .status        (status),
    .status_tgt    (status_tgt),
    .cmd_count     (cmd_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Loader models: BUSY one edge after the pulse, flags updated on BUSY fall.
  int               mode_m   [NUM_TGT];
  int               dur_m    [NUM_TGT];
  logic [2:0]       errcfg_m [NUM_TGT];
  logic [2:0]       err_m    [NUM_TGT];
  int               cnt_m    [NUM_TGT];
  logic [NUM_TGT-1:0] busy_m;

  always @(posedge CLK) begin
    for (int i = 0; i < NUM_TGT; i++) begin
      if (rst) begin
        busy_m[i] <= 1'b0;
        err_m[i]  <= 3'b000;
        cnt_m[i]  <= 0;
      end else if (tgt_rst[i]) begin
        busy_m[i] <= 1'b0;
      end else if (!busy_m[i]) begin
        if (tgt_req_pulse[i] && mode_m[i] != M_NOACK) begin
          busy_m[i] <= 1'b1;
          cnt_m[i]  <= dur_m[i];
        end
      end else if (mode_m[i] != M_HANG) begin
        if (cnt_m[i] <= 1) begin
          busy_m[i] <= 1'b0;
          err_m[i]  <= errcfg_m[i];
        end else begin
          cnt_m[i] <= cnt_m[i] - 1;
        end
      end
    end
  end

  assign tgt_busy = busy_m;
  for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_err
    assign tgt_err[3*gi +: 3] = err_m[gi];
  end

  typedef struct {
    logic [7:0] st;
    int         tgt;
  } exp_t;

  exp_t        sb_q [$];
  logic [15:0] exp_cnt = '0;
  int          acc_cnt = 0;

  always @(posedge CLK) begin
    if (!rst && pkt_valid && pkt_ready) acc_cnt++;
  end

  always @(negedge CLK) begin
    exp_t e;
    if (rst) begin
      exp_cnt = '0;
    end else if (done_pulse) begin
      if (sb_q.size() == 0) begin
        chk("sb_pending", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("status", {24'b0, status}, {24'b0, e.st});
        chk("status_tgt", {30'b0, status_tgt}, 32'(e.tgt));
      end
      exp_cnt = exp_cnt + 16'd1;
      chk("cmd_count", {16'b0, cmd_count}, {16'b0, exp_cnt});
    end
  end

  task automatic set_tgt(input int t, input int mode, input int dur, input logic [2:0] err);
    mode_m[t]   = mode;
    dur_m[t]    = dur;
    errcfg_m[t] = err;
  endtask

  function automatic logic [PW-1:0] make_pkt(input logic [7:0] opc, input logic [7:0] len,
                                             input logic [7:0] cnt);
    logic [PW-1:0] p;
    p = '0;
    for (int b = 4; b < PACKET_SIZE; b++) p[8*b +: 8] = 8'($urandom);
    p[7:0]   = opc;
    p[15:8]  = len;
    p[31:24] = cnt;
    return p;
  endfunction

  // Latencies are counted in cycles after the accepting edge (k=0 is the first).
  task automatic run_cmd(input logic [7:0] opc, input logic [7:0] len, input logic [7:0] exp_st,
                         input int exp_tgt, input logic [NUM_TGT-1:0] exp_mask, input int exp_lat,
                         input logic [NUM_TGT-1:0] exp_rst, input int exp_rst_k);
    logic [PW-1:0]      p;
    logic [NUM_TGT-1:0] rst_seen;
    logic [NUM_TGT-1:0] extra_pulse;
    int                 k;
    int                 rst_k;
    bit                 got_done;
    exp_t               e;
    @(negedge CLK);
    chk("ready_idle", {31'b0, pkt_ready}, 32'd1);
    p = make_pkt(opc, len, 8'd2);
    pkt_data  = p;
    pkt_len   = len;
    pkt_valid = 1'b1;
    e.st  = exp_st;
    e.tgt = exp_tgt;
    sb_q.push_back(e);
    @(negedge CLK);
    pkt_valid   = 1'b0;
    chk("req_pulse", 32'(tgt_req_pulse), 32'(exp_mask));
    chk("tgt_len", {24'b0, tgt_len}, {24'b0, len});
    chk("tgt_packet", {31'b0, tgt_packet == p}, 32'd1);
    k           = 0;
    rst_k       = -1;
    rst_seen    = '0;
    extra_pulse = '0;
    got_done    = 1'b0;
    while (k < 200) begin
      if (tgt_rst != '0) begin
        rst_seen = rst_seen | tgt_rst;
        rst_k    = k;
      end
      if (k > 0) extra_pulse = extra_pulse | tgt_req_pulse;
      if (done_pulse) begin
        got_done = 1'b1;
        break;
      end
      @(negedge CLK);
      k++;
    end
    chk("done_seen", {31'b0, got_done}, 32'd1);
    chk("latency", 32'(k), 32'(exp_lat));
    chk("pulse_once", 32'(extra_pulse), 32'd0);
    chk("tgt_rst", 32'(rst_seen), 32'(exp_rst));
    if (exp_rst != '0) chk("tgt_rst_time", 32'(rst_k), 32'(exp_rst_k));
    chk("ready_at_done", {31'b0, pkt_ready}, 32'd1);
    $display("cmd opc=%02h len=%0d status=%02h tgt=%0d lat=%0d count=%0d",
             opc, len, status, status_tgt, k, cmd_count);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [PW-1:0] p;
    int            cyc;
    int            dones;
    int            acc0;
    logic          seen_done;
    logic [NUM_TGT-1:0] seen_rst;

    rst       = 1'b1;
    pkt_valid = 1'b0;
    pkt_len   = '0;
    pkt_data  = '0;
    for (int t = 0; t < NUM_TGT; t++) set_tgt(t, M_NORMAL, 1, 3'b000);
    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;
    @(negedge CLK);
    chk("rst_ready", {31'b0, pkt_ready}, 32'd1);
    chk("rst_status", {24'b0, status}, 32'd0);
    chk("rst_count", {16'b0, cmd_count}, 32'd0);
    chk("rst_done", {31'b0, done_pulse}, 32'd0);
    chk("rst_len", {24'b0, tgt_len}, 32'd0);
    chk("rst_pkt_zero", {31'b0, tgt_packet == '0}, 32'd1);
    chk("rst_strobes", 32'({tgt_req_pulse, tgt_rst}), 32'd0);
    $display("reset ready=%0d status=%02h count=%0d", pkt_ready, status, cmd_count);

    set_tgt(0, M_NORMAL, 2, 3'b000);
    run_cmd(8'h01, 8'd16, 8'h00, 0, 4'b0001, 5, 4'b0000, 0);
    run_cmd(8'h7F, 8'd4, 8'h01, 0, 4'b0000, 1, 4'b0000, 0);
    set_tgt(1, M_NORMAL, 3, 3'b001);
    run_cmd(8'h02, 8'd8, 8'h08, 1, 4'b0010, 6, 4'b0000, 0);
    set_tgt(3, M_NORMAL, 1, 3'b110);
    run_cmd(8'h04, 8'd32, 8'h30, 3, 4'b1000, 4, 4'b0000, 0);
    run_cmd(8'h00, 8'd1, 8'h01, 0, 4'b0000, 1, 4'b0000, 0);
    run_cmd(8'h05, 8'd1, 8'h01, 0, 4'b0000, 1, 4'b0000, 0);
    set_tgt(0, M_HANG, 1, 3'b000);
    run_cmd(8'h01, 8'd0, 8'h04, 0, 4'b0001, 19, 4'b0001, 17);
    set_tgt(2, M_NOACK, 1, 3'b000);
    run_cmd(8'h03, 8'd12, 8'h02, 2, 4'b0100, 6, 4'b0000, 0);

    // pkt_valid held high across three commands
    set_tgt(2, M_NORMAL, 1, 3'b000);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) sb_q.push_back('{st: 8'h00, tgt: 2});
    acc0      = acc_cnt;
    pkt_data  = make_pkt(8'h03, 8'd9, 8'd1);
    pkt_len   = 8'd9;
    pkt_valid = 1'b1;
    dones     = 0;
    cyc       = 0;
    while (dones < 3 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (done_pulse) dones++;
    end
    pkt_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("burst_dones", 32'(dones), 32'd3);
    chk("burst_accepts", 32'(acc_cnt - acc0), 32'd3);
    $display("burst accepts=%0d dones=%0d count=%0d", acc_cnt - acc0, dones, cmd_count);

    // reset while the loader is stuck in WAIT_DONE
    set_tgt(0, M_HANG, 1, 3'b000);
    @(negedge CLK);
    pkt_data  = make_pkt(8'h01, 8'd7, 8'd0);
    pkt_len   = 8'd7;
    pkt_valid = 1'b1;
    @(negedge CLK);
    pkt_valid = 1'b0;
    repeat (5) @(negedge CLK);
    chk("pre_rst_busy", 32'(tgt_busy), 32'd1);
    rst = 1'b1;
    @(negedge CLK);
    chk("mid_rst_ready", {31'b0, pkt_ready}, 32'd1);
    chk("mid_rst_done", {31'b0, done_pulse}, 32'd0);
    chk("mid_rst_status", {22'b0, status, status_tgt}, 32'd0);
    chk("mid_rst_count", {16'b0, cmd_count}, 32'd0);
    chk("mid_rst_len", {24'b0, tgt_len}, 32'd0);
    chk("mid_rst_pkt_zero", {31'b0, tgt_packet == '0}, 32'd1);
    chk("mid_rst_strobes", 32'({tgt_req_pulse, tgt_rst}), 32'd0);
    @(posedge CLK);
    #1 rst = 1'b0;
    seen_done = 1'b0;
    seen_rst  = '0;
    repeat (6) begin
      @(negedge CLK);
      seen_done = seen_done | done_pulse;
      seen_rst  = seen_rst | tgt_rst;
    end
    chk("post_rst_no_done", {31'b0, seen_done}, 32'd0);
    chk("post_rst_no_tgt_rst", 32'(seen_rst), 32'd0);
    $display("abort ready=%0d status=%02h count=%0d", pkt_ready, status, cmd_count);

    set_tgt(1, M_NORMAL, 1, 3'b000);
    run_cmd(8'h02, 8'd3, 8'h00, 1, 4'b0010, 4, 4'b0000, 0);

    repeat (2) @(negedge CLK);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
